// File: rtl/mem_write_buffer.sv
// Store write buffer: in-order FIFO of CPU stores drained to data memory over valid/ready.
// Optional store-to-load forwarding is enabled by defining STORE_FWD_EN.
module mem_write_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [DATA_W/8-1:0]        st_be,
  output logic                       mem_wr_valid,
  input  logic                       mem_wr_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_be,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign st_ready     = !full;
  assign mem_wr_valid = !empty;
  assign push         = st_valid && st_ready;
  assign pop          = mem_wr_valid && mem_wr_ready;

  // Entry storage is deliberately not reset; only occupied slots are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= st_addr;
      data_mem[wr_ptr] <= st_data;
      be_mem[wr_ptr]   <= st_be;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign mem_addr  = empty ? '0 : addr_mem[rd_ptr];
  assign mem_wdata = empty ? '0 : data_mem[rd_ptr];
  assign mem_be    = empty ? '0 : be_mem[rd_ptr];

`ifdef STORE_FWD_EN
  logic              match_found;
  logic [BE_W-1:0]   match_be;
  logic [DATA_W-1:0] match_data;
  logic [PTR_W-1:0]  idx;
  logic              unused_ld_low;

  assign unused_ld_low = ^ld_addr[1:0];

  // Walk oldest to youngest so the last match seen is the youngest store to that word.
  always_comb begin
    match_found = 1'b0;
    match_be    = '0;
    match_data  = '0;
    idx         = '0;
    fwd_hit     = 1'b0;
    fwd_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_mem[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        match_found = 1'b1;
        match_be    = be_mem[idx];
        match_data  = data_mem[idx];
      end
    end
    if (match_found && (&match_be)) begin
      fwd_hit  = 1'b1;
      fwd_data = match_data;
    end
  end
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule
